// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Contents:
//   BCD_W        width of one BCD digit
//   SEG_W        number of segments per digit {a,b,c,d,e,f,g}
//   scan_state_t scan FSM state (GUARD = all digits off, SHOW = one digit lit)
//   SEG_BLANK    all segments off (active-low)
//   SEG_DIGIT    active-low segment patterns for BCD 0..9
package display_scan_controller_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd_i  BCD digit; values 10..15 produce a blank pattern
//   seg_o  segments {a,b,c,d,e,f,g}, active-low
module seg7_decode
    import display_scan_controller_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    // Table lookup; anything outside 0..9 falls through to blank.
    always_comb begin
        seg_o = SEG_BLANK;
        for (int k = 0; k < 10; k++) begin
            if (bcd_i == BCD_W'(k)) begin
                seg_o = SEG_DIGIT[k];
            end
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for N_DIGITS common-anode 7-segment digits.
// A BCD word arrives over valid/ready, waits in a pending register and is
// committed to the displayed copy only at the end of a full scan, so a frame
// never shows a mix of old and new digits. Each digit slot is preceded by an
// all-off guard interval to suppress ghosting.
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   load_valid   load_data is valid this cycle
//   load_ready   block can accept load_data this cycle
//   load_data    packed BCD word, nibble i is digit i
//   lz_blank_en  leading-zero blanking enable (sampled live)
//   seg_out      segments {a,b,c,d,e,f,g}, active-low
//   an_out       digit enables, active-low, digit 0 on an_out[0]
//   frame_done   one-cycle pulse at the end of each full scan
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [BCD_W*N_DIGITS-1:0] load_data,
    input  logic                      lz_blank_en,
    output logic [SEG_W-1:0]          seg_out,
    output logic [N_DIGITS-1:0]       an_out,
    output logic                      frame_done
);

    localparam int unsigned DATA_W     = BCD_W * N_DIGITS;
    localparam int unsigned IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_MAX    = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned SHOW_LAST  = PRESCALE - 1;
    localparam int unsigned GUARD_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam int unsigned IDX_LAST   = N_DIGITS - 1;

    // Registered state
    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   active_q, active_d;
    logic [DATA_W-1:0]   pending_q, pending_d;
    logic                pending_valid_q, pending_valid_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_done_q;

    // Combinational helpers
    logic                xfer;
    logic                guard_last;
    logic                show_last;
    logic                commit;
    logic [BCD_W-1:0]    nib_sel;
    logic                lz_sel;
    logic [N_DIGITS-1:0] upper_zero;
    logic [SEG_W-1:0]    dec_seg;

    // Ready mirrors the pending register; gated by rst so nothing looks
    // accepted while the block is held in reset.
    assign load_ready = ~pending_valid_q & ~rst;
    assign xfer       = load_valid & load_ready;

    assign guard_last = (state_q == GUARD) &&
                        ((BLANK_CYCLES == 0) || (cnt_q == CNT_W'(GUARD_LAST)));
    assign show_last  = (state_q == SHOW) && (cnt_q == CNT_W'(SHOW_LAST));
    assign commit     = show_last && (idx_q == IDX_W'(IDX_LAST));

    // Scan sequencing: GUARD -> SHOW -> next digit, counter cleared on each change.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (guard_last) begin
            state_d = SHOW;
            cnt_d   = '0;
        end else if (show_last) begin
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_W'(IDX_LAST)) ? '0 : idx_q + IDX_W'(1);
            state_d = (BLANK_CYCLES == 0) ? SHOW : GUARD;
        end
    end

    // Word handling: capture into pending, promote to active at the frame boundary.
    // A word offered on the boundary itself with nothing pending goes straight to active.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (commit) begin
            if (pending_valid_q) begin
                active_d        = pending_q;
                pending_valid_d = 1'b0;
            end else if (xfer) begin
                active_d = load_data;
            end
        end else if (xfer) begin
            pending_d       = load_data;
            pending_valid_d = 1'b1;
        end
    end

    // upper_zero[i]: nibble i and every higher nibble of the word to be shown are zero.
    always_comb begin
        logic run;
        upper_zero = '0;
        run        = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            run           = run && (active_d[i*BCD_W +: BCD_W] == '0);
            upper_zero[i] = run;
        end
    end

    // Scan mux feeding the single shared decoder.
    always_comb begin
        nib_sel = '0;
        lz_sel  = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_sel = active_d[i*BCD_W +: BCD_W];
                lz_sel  = upper_zero[i] && (i != 0);
            end
        end
    end

    seg7_decode u_seg7_decode (
        .bcd_i (nib_sel),
        .seg_o (dec_seg)
    );

    // Outputs follow the next state so they change on the same edge as state/idx.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (state_d == SHOW) begin
            an_d  = ~(N_DIGITS'(1) << idx_d);
            seg_d = (lz_blank_en && lz_sel) ? SEG_BLANK : dec_seg;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= GUARD;
            idx_q           <= '0;
            cnt_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= SEG_BLANK;
            an_q            <= '1;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
            frame_done_q    <= commit;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed testbench for display_scan_controller with N_DIGITS=4, PRESCALE=4,
// BLANK_CYCLES=2 (24-cycle frame). fc tracks the frame cycle: 0,1 guard d0;
// 2..5 show d0; 6,7 guard d1; 8..11 show d1; 14..17 show d2; 20..23 show d3.
module tb_display_scan_controller;

    localparam int FRAME = 24;

    localparam logic [6:0] D0  = 7'b0000001;
    localparam logic [6:0] D1  = 7'b1001111;
    localparam logic [6:0] D2  = 7'b0010010;
    localparam logic [6:0] D3  = 7'b0000110;
    localparam logic [6:0] D4  = 7'b1001100;
    localparam logic [6:0] D5  = 7'b0100100;
    localparam logic [6:0] D7  = 7'b0001111;
    localparam logic [6:0] D8  = 7'b0000000;
    localparam logic [6:0] D9  = 7'b0000100;
    localparam logic [6:0] BLK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        lz_blank_en;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fc     = 0;

    display_scan_controller #(
        .N_DIGITS     (4),
        .PRESCALE     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .lz_blank_en (lz_blank_en),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fc = (fc + 1) % FRAME;
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < FRAME && fc != target; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; load_data = '0; lz_blank_en = 1'b0;
        tick(); tick(); tick();
        checks++; if (an_out !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an_out); end
        checks++; if (seg_out !== BLK) begin errors++; $display("FAIL reset_seg: got %b want %b", seg_out, BLK); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", load_ready); end
        rst = 1'b0;
        #1;
        fc = 0;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b want 1", load_ready); end
    endtask

    task automatic test_idle_scan();
        int pulses;
        tick();
        checks++; if (an_out !== 4'b1111 || seg_out !== BLK) begin errors++; $display("FAIL idle_guard1: got an=%b seg=%b want an=1111 seg=%b", an_out, seg_out, BLK); end
        tick();
        checks++; if (an_out !== 4'b1110 || seg_out !== D0) begin errors++; $display("FAIL idle_show_first: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D0); end
        advance_to(5);
        checks++; if (an_out !== 4'b1110 || seg_out !== D0) begin errors++; $display("FAIL idle_show_last: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D0); end
        tick();
        checks++; if (an_out !== 4'b1111) begin errors++; $display("FAIL idle_guard_d1: got an=%b want 1111", an_out); end
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            if (frame_done === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL idle_fd_early: got %0d pulses want 0", pulses); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL idle_fd_24: got %b want 1", frame_done); end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_fd_width: got %b want 0", frame_done); end
        advance_to(0);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL idle_fd_48: got %b want 1", frame_done); end
    endtask

    task automatic test_load_word();
        advance_to(8);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_before: got %b want 1", load_ready); end
        load_valid = 1'b1; load_data = 16'h1234;
        tick();
        load_valid = 1'b0; load_data = 16'hFFFF;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_after: got %b want 0", load_ready); end
        advance_to(20);
        checks++; if (an_out !== 4'b0111 || seg_out !== D0) begin errors++; $display("FAIL load_old_word: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, D0); end
        advance_to(23);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_commit_cycle: got %b want 0", load_ready); end
        tick();
        checks++; if (load_ready !== 1'b1 || frame_done !== 1'b1) begin errors++; $display("FAIL load_commit: got ready=%b fd=%b want 1 1", load_ready, frame_done); end
        advance_to(2);
        checks++; if (an_out !== 4'b1110 || seg_out !== D4) begin errors++; $display("FAIL load_d0: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D4); end
        advance_to(8);
        checks++; if (an_out !== 4'b1101 || seg_out !== D3) begin errors++; $display("FAIL load_d1: got an=%b seg=%b want an=1101 seg=%b", an_out, seg_out, D3); end
        advance_to(14);
        checks++; if (an_out !== 4'b1011 || seg_out !== D2) begin errors++; $display("FAIL load_d2: got an=%b seg=%b want an=1011 seg=%b", an_out, seg_out, D2); end
        advance_to(20);
        checks++; if (an_out !== 4'b0111 || seg_out !== D1) begin errors++; $display("FAIL load_d3: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, D1); end
        advance_to(0);
    endtask

    task automatic test_lz_blank();
        advance_to(8);
        load_valid = 1'b1; load_data = 16'h0050;
        tick();
        load_valid = 1'b0;
        advance_to(0);
        lz_blank_en = 1'b1;
        advance_to(2);
        checks++; if (an_out !== 4'b1110 || seg_out !== D0) begin errors++; $display("FAIL lz_d0: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D0); end
        advance_to(8);
        checks++; if (an_out !== 4'b1101 || seg_out !== D5) begin errors++; $display("FAIL lz_d1: got an=%b seg=%b want an=1101 seg=%b", an_out, seg_out, D5); end
        advance_to(14);
        checks++; if (an_out !== 4'b1011 || seg_out !== BLK) begin errors++; $display("FAIL lz_d2: got an=%b seg=%b want an=1011 seg=%b", an_out, seg_out, BLK); end
        advance_to(20);
        checks++; if (an_out !== 4'b0111 || seg_out !== BLK) begin errors++; $display("FAIL lz_d3: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, BLK); end
        lz_blank_en = 1'b0;
        tick();
        checks++; if (an_out !== 4'b0111 || seg_out !== D0) begin errors++; $display("FAIL lz_live_off: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, D0); end
        advance_to(0);
    endtask

    task automatic test_invalid_nibble();
        advance_to(8);
        load_valid = 1'b1; load_data = 16'h98A7;
        tick();
        load_valid = 1'b0;
        advance_to(0);
        advance_to(2);
        checks++; if (an_out !== 4'b1110 || seg_out !== D7) begin errors++; $display("FAIL inv_d0: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D7); end
        advance_to(8);
        checks++; if (an_out !== 4'b1101 || seg_out !== BLK) begin errors++; $display("FAIL inv_d1: got an=%b seg=%b want an=1101 seg=%b", an_out, seg_out, BLK); end
        advance_to(14);
        checks++; if (an_out !== 4'b1011 || seg_out !== D8) begin errors++; $display("FAIL inv_d2: got an=%b seg=%b want an=1011 seg=%b", an_out, seg_out, D8); end
        advance_to(20);
        checks++; if (an_out !== 4'b0111 || seg_out !== D9) begin errors++; $display("FAIL inv_d3: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, D9); end
        advance_to(0);
    endtask

    task automatic test_back_to_back();
        advance_to(4);
        load_valid = 1'b1; load_data = 16'h1111;
        tick();
        load_data = 16'h2222;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall: got ready=%b want 0", load_ready); end
        advance_to(23);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_end: got ready=%b want 0", load_ready); end
        tick();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_commit: got ready=%b want 1", load_ready); end
        tick();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_taken: got ready=%b want 0", load_ready); end
        advance_to(2);
        checks++; if (an_out !== 4'b1110 || seg_out !== D1) begin errors++; $display("FAIL b2b_first_d0: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D1); end
        advance_to(20);
        checks++; if (an_out !== 4'b0111 || seg_out !== D1) begin errors++; $display("FAIL b2b_first_d3: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, D1); end
        advance_to(0);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_second_commit: got ready=%b want 1", load_ready); end
        advance_to(2);
        checks++; if (an_out !== 4'b1110 || seg_out !== D2) begin errors++; $display("FAIL b2b_second_d0: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D2); end
        advance_to(20);
        checks++; if (an_out !== 4'b0111 || seg_out !== D2) begin errors++; $display("FAIL b2b_second_d3: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, D2); end
        advance_to(0);
    endtask

    task automatic test_bypass();
        advance_to(23);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %b want 1", load_ready); end
        load_valid = 1'b1; load_data = 16'h5678;
        tick();
        load_valid = 1'b0;
        checks++; if (frame_done !== 1'b1 || load_ready !== 1'b1) begin errors++; $display("FAIL byp_commit: got fd=%b ready=%b want 1 1", frame_done, load_ready); end
        advance_to(2);
        checks++; if (an_out !== 4'b1110 || seg_out !== D8) begin errors++; $display("FAIL byp_d0: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D8); end
        advance_to(8);
        checks++; if (an_out !== 4'b1101 || seg_out !== D7) begin errors++; $display("FAIL byp_d1: got an=%b seg=%b want an=1101 seg=%b", an_out, seg_out, D7); end
        advance_to(20);
        checks++; if (an_out !== 4'b0111 || seg_out !== D5) begin errors++; $display("FAIL byp_d3: got an=%b seg=%b want an=0111 seg=%b", an_out, seg_out, D5); end
        advance_to(0);
    endtask

    task automatic test_reset_mid();
        advance_to(8);
        load_valid = 1'b1; load_data = 16'h4321;
        tick();
        load_valid = 1'b0;
        advance_to(15);
        checks++; if (an_out !== 4'b1011) begin errors++; $display("FAIL rstm_pre_an: got %b want 1011", an_out); end
        rst = 1'b1;
        tick();
        checks++; if (an_out !== 4'b1111 || seg_out !== BLK) begin errors++; $display("FAIL rstm_out: got an=%b seg=%b want an=1111 seg=%b", an_out, seg_out, BLK); end
        checks++; if (load_ready !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstm_ctrl: got ready=%b fd=%b want 0 0", load_ready, frame_done); end
        rst = 1'b0;
        #1;
        fc = 0;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready_release: got %b want 1", load_ready); end
        advance_to(2);
        checks++; if (an_out !== 4'b1110 || seg_out !== D0) begin errors++; $display("FAIL rstm_d0: got an=%b seg=%b want an=1110 seg=%b", an_out, seg_out, D0); end
        advance_to(23);
        tick();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rstm_fd: got %b want 1", frame_done); end
        advance_to(2);
        checks++; if (seg_out !== D0) begin errors++; $display("FAIL rstm_pending_dropped_d0: got %b want %b", seg_out, D0); end
        advance_to(20);
        checks++; if (seg_out !== D0) begin errors++; $display("FAIL rstm_pending_dropped_d3: got %b want %b", seg_out, D0); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_word();
        test_lz_blank();
        test_invalid_nibble();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
